// File: rtl/dmem_bridge.sv
// dmem_bridge: turns MEM-stage data-memory requests into single-beat
// transactions on a variable-latency handshake bus. The pipeline is held
// via mem_stall until the access completes. Bus errors, timeouts and
// misaligned accesses are reported through sticky status outputs.
module dmem_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    input  logic        pipe_adv,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    output logic        mem_err,
    output logic [31:0] err_addr,
    output logic [1:0]  err_cause
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_BUS = 2'b01;
    localparam logic [1:0] CAUSE_TMO = 2'b10;
    localparam logic [1:0] CAUSE_MIS = 2'b11;

    state_t      state, state_nxt;
    logic [15:0] tmo_cnt;

    logic req;
    logic misaligned;
    logic start_acc;
    logic mis_fail;
    logic bus_ok;
    logic bus_fail;
    logic tmo_fail;
    logic busy_end;

    assign req        = mem_ren | mem_wen;
    assign misaligned = |mem_addr[1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, stall and completion-event decode
    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        start_acc = 1'b0;
        mis_fail  = 1'b0;
        bus_ok    = 1'b0;
        bus_fail  = 1'b0;
        tmo_fail  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    mem_stall = 1'b1;
                    if (misaligned) begin
                        mis_fail  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        start_acc = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                // err beats ack; timeout only fires when neither arrived
                if (bus_err) begin
                    bus_fail = 1'b1;
                end else if (bus_ack) begin
                    bus_ok = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_fail = 1'b1;
                end
                if (bus_err || bus_ack || (tmo_cnt == TMO_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (pipe_adv) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Stall must drop as soon as reset asserts, even with a request pending
        mem_stall = mem_stall & rst_n;
    end

    assign busy_end = bus_ok | bus_fail | tmo_fail;

    // Bus request registers: launched in IDLE, held through BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_cyc   <= 1'b0;
            bus_stb   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (start_acc) begin
            bus_cyc   <= 1'b1;
            bus_stb   <= 1'b1;
            bus_we    <= mem_wen;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_wdata <= mem_dout;
        end else if (busy_end) begin
            bus_cyc <= 1'b0;
            bus_stb <= 1'b0;
        end
    end

    // Wait-cycle counter: cleared on launch, counts every BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (start_acc) begin
            tmo_cnt <= '0;
        end else if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // Read data return: updated only when a read completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_din <= '0;
        end else if (bus_ok && !bus_we) begin
            mem_din <= bus_rdata;
        end else if ((bus_fail || tmo_fail) && !bus_we) begin
            mem_din <= ERR_DATA;
        end else if (mis_fail && mem_ren && !mem_wen) begin
            mem_din <= ERR_DATA;
        end
    end

    // Sticky error capture: the first failing access wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err   <= 1'b0;
            err_addr  <= '0;
            err_cause <= 2'b00;
        end else if (!mem_err) begin
            if (mis_fail) begin
                mem_err   <= 1'b1;
                err_addr  <= mem_addr;
                err_cause <= CAUSE_MIS;
            end else if (bus_fail) begin
                mem_err   <= 1'b1;
                err_addr  <= mem_addr;
                err_cause <= CAUSE_BUS;
            end else if (tmo_fail) begin
                mem_err   <= 1'b1;
                err_addr  <= mem_addr;
                err_cause <= CAUSE_TMO;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with TIMEOUT=8 and ERR_DATA=0.
module tb_dmem_bridge;

    logic        clk;
    logic        rst_n;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic        pipe_adv;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic        mem_err;
    logic [31:0] err_addr;
    logic [1:0]  err_cause;

    int checks;
    int errors;

    dmem_bridge #(
        .TIMEOUT  (8),
        .ERR_DATA (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .pipe_adv  (pipe_adv),
        .mem_din   (mem_din),
        .mem_stall (mem_stall),
        .bus_cyc   (bus_cyc),
        .bus_stb   (bus_stb),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .mem_err   (mem_err),
        .err_addr  (err_addr),
        .err_cause (err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_dout  = '0;
        pipe_adv  = 1'b0;
        bus_rdata = '0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic leave_done();
        pipe_adv = 1'b1;
        step();
        pipe_adv = 1'b0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({bus_cyc, bus_stb, bus_we} !== 3'b000) begin
            errors++; $display("FAIL reset_bus_ctrl got %b exp 000", {bus_cyc, bus_stb, bus_we});
        end
        checks++;
        if ({bus_addr, bus_wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_bus_data got %h exp 0", {bus_addr, bus_wdata});
        end
        checks++;
        if (mem_din !== 32'h0) begin
            errors++; $display("FAIL reset_mem_din got %h exp 0", mem_din);
        end
        checks++;
        if ({mem_err, err_cause, err_addr} !== 35'h0) begin
            errors++; $display("FAIL reset_err got %b %b %h exp 0", mem_err, err_cause, err_addr);
        end
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b exp 0", mem_stall);
        end
    endtask

    task automatic test_zero_wait_read();
        int stalls;
        mem_ren  = 1'b1;
        mem_addr = 32'h0000_0010;
        #1;
        stalls = int'(mem_stall);
        step();
        stalls += int'(mem_stall);
        checks++;
        if ({bus_cyc, bus_stb, bus_we, bus_addr} !== {3'b110, 32'h10}) begin
            errors++; $display("FAIL zw_bus got %b%b%b %h exp 110 00000010", bus_cyc, bus_stb, bus_we, bus_addr);
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        pipe_adv  = 1'b1;
        step();
        bus_ack = 1'b0;
        stalls += int'(mem_stall);
        checks++;
        if ({bus_cyc, mem_din} !== {1'b0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL zw_done got cyc=%b din=%h exp cyc=0 din=deadbeef", bus_cyc, mem_din);
        end
        step();
        mem_ren  = 1'b0;
        pipe_adv = 1'b0;
        #1;
        stalls += int'(mem_stall);
        checks++;
        if (mem_din !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL zw_hold got %h exp deadbeef", mem_din);
        end
        checks++;
        if (stalls !== 2) begin
            errors++; $display("FAIL zw_stall_cycles got %0d exp 2", stalls);
        end
    endtask

    task automatic test_write_wait();
        int stalls;
        int bad_hold;
        mem_wen  = 1'b1;
        mem_addr = 32'h0000_0020;
        mem_dout = 32'h1234_5678;
        #1;
        stalls   = int'(mem_stall);
        bad_hold = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            stalls += int'(mem_stall);
            if ({bus_cyc, bus_stb, bus_we, bus_wdata, bus_addr} !== {3'b111, 32'h1234_5678, 32'h20})
                bad_hold++;
            if (i == 4) bus_ack = 1'b1;
        end
        checks++;
        if (bad_hold !== 0) begin
            errors++; $display("FAIL wr_hold got %0d bad cycles exp 0", bad_hold);
        end
        step();
        bus_ack = 1'b0;
        checks++;
        if ({bus_cyc, mem_stall, mem_err} !== 3'b000) begin
            errors++; $display("FAIL wr_done got cyc/stall/err=%b exp 000", {bus_cyc, mem_stall, mem_err});
        end
        checks++;
        if (mem_din !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_din_kept got %h exp deadbeef", mem_din);
        end
        leave_done();
        checks++;
        if (stalls !== 6) begin
            errors++; $display("FAIL wr_stall_cycles got %0d exp 6", stalls);
        end
    endtask

    task automatic test_timeout();
        int busy;
        mem_ren  = 1'b1;
        mem_addr = 32'h0000_0040;
        busy     = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!bus_cyc) break;
            busy++;
        end
        checks++;
        if (busy !== 8) begin
            errors++; $display("FAIL tmo_busy_cycles got %0d exp 8", busy);
        end
        checks++;
        if ({mem_err, err_cause, err_addr} !== {1'b1, 2'b10, 32'h40}) begin
            errors++; $display("FAIL tmo_err got %b %b %h exp 1 10 00000040", mem_err, err_cause, err_addr);
        end
        checks++;
        if ({mem_stall, mem_din} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL tmo_release got stall=%b din=%h exp 0 0", mem_stall, mem_din);
        end
        leave_done();
    endtask

    task automatic test_misaligned();
        do_reset();
        mem_ren  = 1'b1;
        mem_addr = 32'h0000_0006;
        #1;
        checks++;
        if (mem_stall !== 1'b1) begin
            errors++; $display("FAIL mis_idle_stall got %b exp 1", mem_stall);
        end
        step();
        checks++;
        if ({bus_cyc, mem_stall} !== 2'b00) begin
            errors++; $display("FAIL mis_no_bus got cyc/stall=%b exp 00", {bus_cyc, mem_stall});
        end
        checks++;
        if ({mem_err, err_cause, err_addr} !== {1'b1, 2'b11, 32'h6}) begin
            errors++; $display("FAIL mis_err got %b %b %h exp 1 11 00000006", mem_err, err_cause, err_addr);
        end
        leave_done();
    endtask

    task automatic test_second_error();
        mem_ren  = 1'b1;
        mem_addr = 32'h0000_0050;
        step();
        checks++;
        if (bus_cyc !== 1'b1) begin
            errors++; $display("FAIL err2_cyc got %b exp 1", bus_cyc);
        end
        bus_err = 1'b1;
        step();
        bus_err = 1'b0;
        checks++;
        if ({bus_cyc, err_cause, err_addr} !== {1'b0, 2'b11, 32'h6}) begin
            errors++; $display("FAIL err2_sticky got %b %b %h exp 0 11 00000006", bus_cyc, err_cause, err_addr);
        end
        leave_done();
    endtask

    task automatic test_done_hold();
        int cyc_seen;
        int bad;
        mem_ren  = 1'b1;
        mem_addr = 32'h0000_0060;
        cyc_seen = 0;
        bad      = 0;
        step();
        cyc_seen += int'(bus_cyc);
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        step();
        bus_ack = 1'b0;
        cyc_seen += int'(bus_cyc);
        for (int i = 0; i < 3; i++) begin
            step();
            cyc_seen += int'(bus_cyc);
            // req still high: stall=0 proves DONE rather than IDLE
            if ({mem_stall, mem_din} !== {1'b0, 32'hCAFE_F00D}) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL hold_done got %0d bad cycles exp 0", bad);
        end
        checks++;
        if (cyc_seen !== 1) begin
            errors++; $display("FAIL hold_one_txn got %0d bus cycles exp 1", cyc_seen);
        end
        leave_done();
    endtask

    task automatic test_mid_reset();
        mem_ren  = 1'b1;
        mem_addr = 32'h0000_0070;
        step();
        checks++;
        if ({bus_cyc, mem_stall, mem_err} !== 3'b111) begin
            errors++; $display("FAIL rst_pre got cyc/stall/err=%b exp 111", {bus_cyc, mem_stall, mem_err});
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_cyc, bus_stb, mem_stall, mem_err} !== 4'b0000) begin
            errors++; $display("FAIL rst_async got cyc/stb/stall/err=%b exp 0000", {bus_cyc, bus_stb, mem_stall, mem_err});
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_stall !== 1'b1) begin
            errors++; $display("FAIL rst_idle_stall got %b exp 1", mem_stall);
        end
        step();
        checks++;
        if ({bus_stb, bus_addr} !== {1'b1, 32'h70}) begin
            errors++; $display("FAIL rst_reissue got stb=%b addr=%h exp 1 00000070", bus_stb, bus_addr);
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_2222;
        step();
        bus_ack = 1'b0;
        leave_done();
    endtask

    task automatic test_err_priority();
        mem_ren  = 1'b1;
        mem_addr = 32'h0000_0080;
        step();
        bus_ack   = 1'b1;
        bus_err   = 1'b1;
        bus_rdata = 32'hAAAA_5555;
        step();
        bus_ack = 1'b0;
        bus_err = 1'b0;
        checks++;
        if ({mem_err, err_cause, err_addr} !== {1'b1, 2'b01, 32'h80}) begin
            errors++; $display("FAIL prio_err got %b %b %h exp 1 01 00000080", mem_err, err_cause, err_addr);
        end
        checks++;
        if ({bus_cyc, mem_din} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL prio_din got cyc=%b din=%h exp 0 00000000", bus_cyc, mem_din);
        end
        leave_done();
    endtask

    task automatic test_back_to_back();
        int n;
        mem_ren  = 1'b1;
        mem_addr = 32'h0000_0090;
        step();
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_0001;
        pipe_adv  = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++;
        if (mem_din !== 32'h1) begin
            errors++; $display("FAIL b2b_first got %h exp 00000001", mem_din);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (n == 1) begin
                mem_addr = 32'h0000_0094;
                pipe_adv = 1'b0;
            end
            if (bus_stb) break;
        end
        checks++;
        if ({n, bus_addr} !== {32'd2, 32'h94}) begin
            errors++; $display("FAIL b2b_gap got %0d cycles addr=%h exp 2 00000094", n, bus_addr);
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_0002;
        step();
        bus_ack = 1'b0;
        checks++;
        if (mem_din !== 32'h2) begin
            errors++; $display("FAIL b2b_second got %h exp 00000002", mem_din);
        end
        leave_done();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_timeout();
        test_misaligned();
        test_second_error();
        test_done_hold();
        test_mid_reset();
        test_err_priority();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "simulation time limit");
    end

endmodule
